// File: rtl/rsa_stream_if.sv
// Streaming operand loader and cypher unloader for the rsa4k core.
// Words arrive LSW first as modulus, exponent, then message; the cypher leaves LSW first.
module rsa_stream_if #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reuse_key,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WORD-1:0]  s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WORD-1:0]  m_data,
    output logic             m_last,
    output logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] exponent,
    output logic [WIDTH-1:0] message,
    output logic             go,
    input  logic [WIDTH-1:0] cypher,
    input  logic             done,
    output logic             busy,
    output logic             frame_err
);

    localparam int NWORDS = WIDTH / WORD;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_MOD,
        S_LD_EXP,
        S_LD_MSG,
        S_RUN,
        S_UNLOAD
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_key_loaded;
    logic             r_armed;
    logic             r_go;
    logic             r_frame_err;
    logic [WIDTH-1:0] r_modulus;
    logic [WIDTH-1:0] r_exponent;
    logic [WIDTH-1:0] r_message;
    logic [WIDTH-1:0] r_result;

    logic w_loading;
    logic w_s_hs;
    logic w_m_hs;
    logic w_last_cnt;
    logic w_err;
    logic w_capture;

    assign w_loading  = (r_state == S_LD_MOD) || (r_state == S_LD_EXP)
                     || (r_state == S_LD_MSG);
    assign w_s_hs     = s_valid && w_loading;
    assign w_m_hs     = (r_state == S_UNLOAD) && m_ready;
    assign w_last_cnt = (r_cnt == CW'(NWORDS - 1));
    // Only the final message word may carry s_last, and it must.
    assign w_err      = w_s_hs && ((r_state == S_LD_MSG) ? (s_last != w_last_cnt)
                                                         : s_last);
    assign w_capture  = (r_state == S_RUN) && r_armed && done;

    assign s_ready   = w_loading;
    assign m_valid   = (r_state == S_UNLOAD);
    assign m_data    = r_result[r_cnt*WORD +: WORD];
    assign m_last    = m_valid && w_last_cnt;
    assign busy      = (r_state != S_IDLE);
    assign go        = r_go;
    assign frame_err = r_frame_err;
    assign modulus   = r_modulus;
    assign exponent  = r_exponent;
    assign message   = r_message;

    // Operand assembly and cypher capture; operands stay put outside their load phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_modulus  <= '0;
            r_exponent <= '0;
            r_message  <= '0;
            r_result   <= '0;
        end else begin
            if (w_s_hs) begin
                unique case (r_state)
                    S_LD_MOD: r_modulus[r_cnt*WORD +: WORD]  <= s_data;
                    S_LD_EXP: r_exponent[r_cnt*WORD +: WORD] <= s_data;
                    S_LD_MSG: r_message[r_cnt*WORD +: WORD]  <= s_data;
                    default:  ;
                endcase
            end
            if (w_capture) begin
                r_result <= cypher;
            end
        end
    end

    // Job sequencing: load sections, core handshake, unload, framing checks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_key_loaded <= 1'b0;
            r_armed      <= 1'b0;
            r_go         <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (s_valid) begin
                        r_cnt   <= '0;
                        r_state <= (reuse_key && r_key_loaded) ? S_LD_MSG : S_LD_MOD;
                    end
                end
                S_LD_MOD, S_LD_EXP, S_LD_MSG: begin
                    if (w_err) begin
                        r_frame_err  <= 1'b1;
                        r_key_loaded <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_IDLE;
                    end else if (w_s_hs) begin
                        if (w_last_cnt) begin
                            r_cnt <= '0;
                            if (r_state == S_LD_MOD) begin
                                r_state <= S_LD_EXP;
                            end else if (r_state == S_LD_EXP) begin
                                r_state      <= S_LD_MSG;
                                r_key_loaded <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                                r_go    <= 1'b1;
                                r_armed <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    // A done still high from the previous job is ignored until it drops.
                    if (!r_armed) begin
                        if (!done) begin
                            r_armed <= 1'b1;
                        end
                    end else if (done) begin
                        r_go    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (w_m_hs) begin
                        if (w_last_cnt) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_stream_if.sv
// Randomized bench for rsa_stream_if with a small modexp core stub.
// Expected cypher words come from plain modular exponentiation of the sent operands.
module tb_rsa_stream_if;

    localparam int WIDTH  = 4096;
    localparam int WORD   = 32;
    localparam int NWORDS = WIDTH / WORD;

    logic             clk = 1'b0;
    logic             reset;
    logic             reuse_key;
    logic             s_valid;
    logic             s_ready;
    logic [WORD-1:0]  s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WORD-1:0]  m_data;
    logic             m_last;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] message;
    logic             go;
    logic [WIDTH-1:0] cypher;
    logic             done;
    logic             busy;
    logic             frame_err;

    int checks = 0;
    int errors = 0;

    // model state
    bit               key_m = 0;
    logic [WIDTH-1:0] km, ke;
    logic [WIDTH-1:0] nm, ne, ng;
    logic [WIDTH-1:32] core_upper = '0;

    // core stub state
    logic go_q = 1'b0;
    int   core_cnt = 0;

    rsa_stream_if #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk       (clk),
        .reset     (reset),
        .reuse_key (reuse_key),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .modulus   (modulus),
        .exponent  (exponent),
        .message   (message),
        .go        (go),
        .cypher    (cypher),
        .done      (done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned modexp(longint unsigned b,
                                               longint unsigned e,
                                               longint unsigned n);
        longint unsigned r = 1;
        b = b % n;
        while (e != 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r % n;
    endfunction

    function automatic logic [WIDTH-1:0] rand_vec(logic [31:0] low, bit fill);
        logic [WIDTH-1:0] v = '0;
        if (fill) begin
            for (int w = 1; w < NWORDS; w++) v[w*WORD +: WORD] = $urandom;
        end
        v[31:0] = low;
        return v;
    endfunction

    // Core stub: restarts on go rising, keeps the old done high a few cycles,
    // then answers after a fixed latency and holds done until the next job.
    always @(posedge clk) begin
        go_q <= go;
        if (go && !go_q) begin
            core_cnt <= 20;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 18) done <= 1'b0;
            if (core_cnt == 1) begin
                done   <= 1'b1;
                cypher <= {core_upper,
                           32'(modexp(64'(message[31:0]), 64'(exponent[31:0]),
                                      64'(modulus[31:0])))};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input bit reuse, input bit gaps, input int early,
                           input bit drop_last, input bit abort);
        logic [WORD-1:0]  q[$];
        logic [WIDTH-1:0] expc;
        bit load_key, hs, err_exp;
        int total, stop_idx, idx, cyc, budget, fe_seen, go_drop, beat;
        load_key = !(reuse && key_m);
        if (load_key) begin
            for (int k = 0; k < NWORDS; k++) q.push_back(nm[k*WORD +: WORD]);
            for (int k = 0; k < NWORDS; k++) q.push_back(ne[k*WORD +: WORD]);
        end
        for (int k = 0; k < NWORDS; k++) q.push_back(ng[k*WORD +: WORD]);
        total    = q.size();
        err_exp  = (early >= 0) || drop_last;
        stop_idx = (early >= 0) ? early : total - 1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        reuse_key = reuse;
        idx = 0; cyc = 0; budget = 0; fe_seen = 0;
        while (idx <= stop_idx && budget < 8 * total + 50) begin
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = q[idx];
            s_last  = (idx == early) || (idx == total - 1 && !drop_last);
            hs      = s_valid && s_ready;
            @(posedge clk);
            cyc++;
            budget++;
            if (hs) idx++;
            @(negedge clk);
            if (frame_err && idx <= stop_idx) fe_seen++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("send_words", idx, stop_idx + 1);
        chk("early_frame_err", fe_seen, 0);
        if (err_exp) begin
            chk("frame_err", frame_err, 1);
            chk("err_busy", busy, 0);
            key_m = 0;
            @(negedge clk);
            chk("frame_err_pulse", frame_err, 0);
            return;
        end
        chk("no_frame_err", frame_err, 0);
        chk("go_rise", go, 1);
        chk("run_busy", busy, 1);
        if (load_key) begin
            km = nm;
            ke = ne;
            key_m = 1;
        end
        chk("op_mod", modulus == km, 1);
        chk("op_exp", exponent == ke, 1);
        chk("op_msg", message == ng, 1);
        if (!gaps) chk("in_latency", cyc, 1 + (load_key ? 3 : 1) * NWORDS);
        if (abort) begin
            repeat (10) @(negedge clk);
            chk("abort_go_pre", go, 1);
            reset = 1'b1;
            @(negedge clk);
            chk("abort_go", go, 0);
            chk("abort_busy", busy, 0);
            chk("abort_mvalid", m_valid, 0);
            reset = 1'b0;
            key_m = 0;
            return;
        end
        budget = 0; go_drop = 0;
        while (!m_valid && budget < 200) begin
            if (!go) go_drop++;
            @(negedge clk);
            budget++;
        end
        chk("go_held", go_drop, 0);
        chk("run_done", m_valid, 1);
        chk("go_fall", go, 0);
        expc = {core_upper,
                32'(modexp(64'(ng[31:0]), 64'(ke[31:0]), 64'(km[31:0])))};
        beat = 0; budget = 0;
        while (beat < NWORDS && budget < 8 * NWORDS) begin
            if (m_valid) begin
                chk($sformatf("beat%0d", beat), m_data, expc[beat*WORD +: WORD]);
                chk($sformatf("last%0d", beat), m_last, beat == NWORDS - 1);
            end
            m_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = m_valid && m_ready;
            @(posedge clk);
            if (hs) beat++;
            @(negedge clk);
            budget++;
        end
        m_ready = 1'b0;
        chk("beats", beat, NWORDS);
        chk("end_busy", busy, 0);
        chk("end_mvalid", m_valid, 0);
        chk("end_go", go, 0);
    endtask

    task automatic set_ops(input logic [31:0] m, input logic [31:0] e,
                           input logic [31:0] g, input bit fill);
        nm = rand_vec(m, fill);
        ne = rand_vec(e, fill);
        ng = rand_vec(g, fill);
    endtask

    initial begin
        logic [WIDTH-1:0] tmp;
        logic [31:0] rm;
        reset = 1'b1; reuse_key = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b0; cypher = '0; done = 1'b0;
        km = '0; ke = '0;
        repeat (3) @(negedge clk);
        chk("rst_sready", s_ready, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_mlast", m_last, 0);
        chk("rst_go", go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ops", (modulus | exponent | message) == '0, 1);
        reset = 1'b0;

        set_ops(77, 13, 8, 0);
        run_job(0, 0, -1, 0, 0);
        set_ops(0, 0, 2, 0);
        run_job(1, 0, -1, 0, 0);
        set_ops(77, 37, 50, 0);
        run_job(0, 0, -1, 0, 0);
        set_ops(77, 13, 8, 0);
        run_job(0, 0, 5, 0, 0);
        run_job(1, 0, -1, 0, 0);
        set_ops(0, 0, 3, 0);
        run_job(1, 0, -1, 1, 0);
        set_ops(77, 13, 8, 0);
        run_job(0, 1, -1, 0, 0);
        run_job(0, 0, -1, 0, 1);
        run_job(0, 0, -1, 0, 0);

        for (int j = 0; j < 4; j++) begin
            rm = $urandom_range(3, 65535);
            set_ops(rm, $urandom, $urandom_range(0, rm - 1), 1);
            tmp = rand_vec(0, 1);
            core_upper = tmp[WIDTH-1:32];
            run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_stream_if.md
Name: rsa_stream_if

Overview:
Host-side streaming front/back end for the rsa4k modular-exponentiation core. Accepts a word stream (valid/ready) carrying modulus, exponent and message, and assembles them into WIDTH-bit operand registers. It then drives the core's go/done handshake and streams the WIDTH-bit cypher back out as words. Sits between the system bus adapter and rsa4k; its operand outputs connect directly to rsa4k message/exponent/modulus/go, and its cypher/done inputs come from rsa4k.

Parameters:
WIDTH, 4096, operand width in bits (must equal rsa4k width)
WORD, 32, stream word width; WIDTH % WORD == 0
NWORDS, WIDTH/WORD (128), derived local parameter: words per operand

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
reuse_key  in  1  sampled in IDLE on job start; 1 = skip modulus/exponent load if a key is held
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
s_data  in  WORD  input word
s_last  in  1  marks final word of a job
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts output word
m_data  out  WORD  output cypher word
m_last  out  1  final output word (word NWORDS-1)
modulus  out  WIDTH  to rsa4k.modulus
exponent  out  WIDTH  to rsa4k.exponent
message  out  WIDTH  to rsa4k.message
go  out  1  to rsa4k.go
cypher  in  WIDTH  from rsa4k.cypher
done  in  1  from rsa4k.done
busy  out  1  high in any state except IDLE
frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (sync, active-high): state=IDLE; all outputs 0; modulus/exponent/message/result register/word counter 0; key_loaded=0. Reset in any state aborts the job; go is 0 from the next edge.
- States: IDLE, LD_MOD, LD_EXP, LD_MSG, RUN, UNLOAD.
- IDLE: s_ready=0. When s_valid=1: go to LD_MSG if reuse_key=1 and key_loaded=1, else to LD_MOD. No word is consumed in this cycle; there is a one-cycle bubble.
- LD_*: s_ready=1. Each accepted word k (counter 0..NWORDS-1) is written to bits [k*WORD +: WORD] of the target register, least-significant word first. Counter wraps to 0 at each section change. LD_MOD→LD_EXP and LD_EXP→LD_MSG after word NWORDS-1. LD_EXP completion sets key_loaded=1.
- Framing: s_last must be 1 exactly on message word NWORDS-1.
  - s_last=1 on any earlier accepted word: frame_err pulses the next cycle, key_loaded=0, return to IDLE.
  - s_last=0 on the final message word: same error action.
  - Operand registers keep partially written contents.
- LD_MSG→RUN after a valid final word.
- RUN: s_ready=0; go=1 from the first RUN cycle.
  - An internal armed flag sets on the first RUN cycle with done=0. A done=1 before arming (stale done from the previous job) is ignored.
  - On done=1 while armed: capture cypher into the result register, go=0 on the next cycle, state→UNLOAD.
  - No timeout.
- UNLOAD:
  - m_valid=1; m_data = result[k*WORD +: WORD], k=0..NWORDS-1, LSW first; m_last=1 when k=NWORDS-1.
  - k advances on m_valid&m_ready; m_data/m_last are stable while m_ready=0.
  - After the last beat is accepted: m_valid=0, state→IDLE.
  - Changes on cypher/done during UNLOAD are ignored.
- Operand outputs hold their values in all states; the core sees stable operands throughout RUN.
- Throughput: 1 word/cycle in LD_* and UNLOAD with continuous handshakes. Full-job input latency is 1 + 3*NWORDS cycles.

Test Plan:
- Encrypt: full job with modulus=77, exponent=13, message=8; word0 non-zero, remaining 127 words 0 per operand; s_last on word 383 → go rises on first RUN cycle and stays high until done; m_data beat0=0x00000032 (50), beats1..127=0, m_last on beat 127; busy falls after last beat.
- Decrypt: reuse_key=0 full job, modulus=77, exponent=37, message=50 → beat0=0x00000008. Exercises stale done from the prior job being ignored before arming.
- Key reuse: after the encrypt job, reuse_key=1, stream only 128 message words with value 2 → no modulus/exponent words consumed; beat0=0x0000001E (30 = 2^13 mod 77).
- Framing: s_last asserted on modulus word 5 → frame_err pulse, IDLE, key_loaded=0. A following reuse_key=1 job must load the full 384 words.
- Backpressure: random m_ready/s_valid gaps (≈50%) → data identical to the encrypt case; m_data stable while m_ready=0; no dropped or duplicated words.
- Reset mid-RUN (10 cycles after go rises) → go=0, busy=0, m_valid=0 after the edge; the next full job produces correct cypher 50.
